aes_pipe_batch_ctrl: RTL and testbench
======================================

# aes_pipe_batch_ctrl

Clock-domain-local sequencer for the pipelined AES-128 core. Issues key-load and encrypt-start pulses, tracks per-batch completions and enforces a completion watchdog. Produces a capture trigger and status/error flags for the register block. Sits between the register interface and the pipeline top, in the `clk` domain.

## Interface
Parameters:
- pCOUNT_WIDTH, 16, width of batch length and completion counter
- pKEY_CYCLES, 14, cycles from `pipe_load_key` until round keys are stable
- pTIMEOUT, 4096, max cycles allowed between go/completions in RUN
- pCYCLE_WIDTH, 32, width of batch duration counter

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock
- reset_n  in  1  async active-low reset
- key_load_req  in  1  pulse: request key load
- go_req  in  1  pulse: start batch
- batch_len  in  pCOUNT_WIDTH  blocks in batch, sampled on accepted go
- abort  in  1  pulse: terminate current activity
- clear_errors  in  1  clears sticky errors
- pipe_busy  in  1  pipeline busy flag
- pipe_block_done  in  1  one pulse per block written to output FIFO
- pipe_load_key  out  1  one-cycle key-load pulse to pipeline
- pipe_encrypt_go  out  1  one-cycle start pulse to pipeline
- key_valid  out  1  round keys stable
- busy  out  1  batch in progress
- done  out  1  one-cycle batch-complete pulse
- trig  out  1  capture trigger
- blocks_done  out  pCOUNT_WIDTH  completions in current/last batch
- cycles  out  pCYCLE_WIDTH  duration of current/last batch
- err_timeout, err_overrun, err_reject  out  1 each  sticky errors

## Operation
- States: IDLE, KEY, READY, RUN, DRAIN.
- IDLE: key_load_req -> KEY. go_req -> err_reject.
- KEY: counter runs pKEY_CYCLES; at expiry key_valid=1 -> READY. go_req or key_load_req -> err_reject.
- READY: key_load_req -> key_valid=0, KEY. go_req with batch_len!=0 -> RUN; batch_len==0 -> err_reject, stay.
- RUN: each pipe_block_done increments blocks_done and reloads watchdog. The completion that makes blocks_done==latched length -> DRAIN. Watchdog reaching pTIMEOUT -> err_timeout, READY, no done.
- DRAIN: when pipe_busy==0 -> done pulse, READY.
- pipe_block_done outside RUN -> err_overrun; blocks_done unchanged.
- key_load_req or go_req in RUN/DRAIN -> err_reject, ignored.
- abort: RUN/DRAIN -> READY, no done; KEY -> IDLE with key_valid=0; IDLE/READY no effect.
- Priority: abort > key_load_req > go_req. Simultaneous key_load_req+go_req in READY: key load taken, err_reject set.
- Error set beats clear_errors in the same cycle.
- cycles saturates at all-ones. blocks_done and cycles hold their values after batch end until the next accepted go.

## Timing
- Reset (async, any state): state IDLE, all outputs 0, counters 0, key_valid=0.
- Accepted key_load_req at cycle t: pipe_load_key=1 at t+1 only. key_valid=1 at t+1+pKEY_CYCLES.
- Accepted go_req at cycle t:
  - t+1: pipe_encrypt_go=1 (one cycle), busy=1, trig=1, blocks_done=0, cycles=0.
  - cycles increments every cycle from t+2 while in RUN/DRAIN.
- pipe_block_done at cycle c: blocks_done updated at c+1. Final completion: trig=0 at c+1.
- DRAIN sees pipe_busy==0 at cycle d: done=1 and busy=0 at d+1; state READY at d+1.
- Timeout/abort: busy=0 and trig=0 one cycle after the event.
- Errors register one cycle after the causing event.

## Test plan
- Reset, key_load_req -> pipe_load_key pulse at t+1, key_valid high exactly 15 cycles after request (pKEY_CYCLES=14).
- batch_len=3, go, three block_done pulses, pipe_busy low 2 cycles later -> blocks_done=3, one done pulse, busy low with done, trig low after 3rd completion.
- go_req in IDLE and go with batch_len=0 in READY -> err_reject=1, no pipe_encrypt_go; clear_errors -> 0.
- batch_len=2, only one completion -> err_timeout after 4096 idle cycles, READY, no done, blocks_done=1.
- Extra pipe_block_done in DRAIN -> err_overrun=1, blocks_done stays 2.
- abort in RUN, then reset_n low mid-KEY -> READY/no done, then all outputs 0 immediately, key_valid=0.

Source files
------------

// File: rtl/aes_pipe_batch_ctrl.sv
// Batch sequencer for the pipelined AES-128 core: key load, encrypt start,
// completion tracking, completion watchdog and sticky error flags.
module aes_pipe_batch_ctrl #(
  parameter int pCOUNT_WIDTH = 16,
  parameter int pKEY_CYCLES  = 14,
  parameter int pTIMEOUT     = 4096,
  parameter int pCYCLE_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    key_load_req,
  input  logic                    go_req,
  input  logic [pCOUNT_WIDTH-1:0] batch_len,
  input  logic                    abort,
  input  logic                    clear_errors,
  input  logic                    pipe_busy,
  input  logic                    pipe_block_done,
  output logic                    pipe_load_key,
  output logic                    pipe_encrypt_go,
  output logic                    key_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    trig,
  output logic [pCOUNT_WIDTH-1:0] blocks_done,
  output logic [pCYCLE_WIDTH-1:0] cycles,
  output logic                    err_timeout,
  output logic                    err_overrun,
  output logic                    err_reject
);

  localparam int KW = $clog2(pKEY_CYCLES + 1);
  localparam int WW = $clog2(pTIMEOUT + 1);
  localparam logic [KW-1:0] KEY_LAST = KW'(pKEY_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(pTIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_READY,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [KW-1:0]           kcnt_q, kcnt_d;
  logic [WW-1:0]           wd_q, wd_d;
  logic [pCOUNT_WIDTH-1:0] len_q, len_d;
  logic [pCOUNT_WIDTH-1:0] blk_q, blk_d;
  logic [pCYCLE_WIDTH-1:0] cyc_q, cyc_d;

  logic load_q, load_d;
  logic go_q, go_d;
  logic kv_q, kv_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic trig_q, trig_d;
  logic et_q, et_d;
  logic eo_q, eo_d;
  logic er_q, er_d;

  logic active;
  logic abort_eff;
  logic key_ok;
  logic go_ok;
  logic rej_set;
  logic ovr_set;
  logic tmo_set;
  logic last_blk;

  always_comb begin
    active = (state_q == S_KEY) ||
             (state_q == S_RUN) ||
             (state_q == S_DRAIN);
    abort_eff = abort && active;
    key_ok = !abort_eff && key_load_req &&
             ((state_q == S_IDLE) || (state_q == S_READY));
    go_ok = !abort_eff && go_req && !key_load_req &&
            (state_q == S_READY) && (batch_len != '0);
    // Any request not taken this cycle is a rejected request.
    rej_set = !abort_eff &&
              ((go_req && !go_ok) || (key_load_req && !key_ok));
    ovr_set = pipe_block_done && (state_q != S_RUN);
    last_blk = (blk_q + pCOUNT_WIDTH'(1)) == len_q;
    tmo_set = (state_q == S_RUN) && !abort_eff &&
              !pipe_block_done && (wd_q == WD_LAST);
  end

  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    wd_d    = wd_q;
    len_d   = len_q;
    blk_d   = blk_q;
    cyc_d   = cyc_q;
    load_d  = 1'b0;
    go_d    = 1'b0;
    done_d  = 1'b0;
    kv_d    = kv_q;
    busy_d  = busy_q;
    trig_d  = trig_q;

    if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
      cyc_d = (&cyc_q) ? cyc_q : cyc_q + pCYCLE_WIDTH'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (key_ok) begin
          state_d = S_KEY;
          kcnt_d  = '0;
          load_d  = 1'b1;
        end
      end
      S_KEY: begin
        if (abort_eff) begin
          state_d = S_IDLE;
          kv_d    = 1'b0;
        end else if (kcnt_q == KEY_LAST) begin
          state_d = S_READY;
          kv_d    = 1'b1;
        end else begin
          kcnt_d = kcnt_q + KW'(1);
        end
      end
      S_READY: begin
        if (key_ok) begin
          state_d = S_KEY;
          kv_d    = 1'b0;
          kcnt_d  = '0;
          load_d  = 1'b1;
        end else if (go_ok) begin
          state_d = S_RUN;
          go_d    = 1'b1;
          busy_d  = 1'b1;
          trig_d  = 1'b1;
          blk_d   = '0;
          cyc_d   = '0;
          wd_d    = '0;
          len_d   = batch_len;
        end
      end
      S_RUN: begin
        if (abort_eff) begin
          state_d = S_READY;
          busy_d  = 1'b0;
          trig_d  = 1'b0;
        end else if (pipe_block_done) begin
          blk_d = blk_q + pCOUNT_WIDTH'(1);
          wd_d  = '0;
          if (last_blk) begin
            state_d = S_DRAIN;
            trig_d  = 1'b0;
          end
        end else if (tmo_set) begin
          state_d = S_READY;
          busy_d  = 1'b0;
          trig_d  = 1'b0;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_DRAIN: begin
        if (abort_eff) begin
          state_d = S_READY;
          busy_d  = 1'b0;
          trig_d  = 1'b0;
        end else if (!pipe_busy) begin
          state_d = S_READY;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Setting an error wins over a same-cycle clear.
  always_comb begin
    et_d = tmo_set || (et_q && !clear_errors);
    eo_d = ovr_set || (eo_q && !clear_errors);
    er_d = rej_set || (er_q && !clear_errors);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      kcnt_q  <= '0;
      wd_q    <= '0;
      len_q   <= '0;
      blk_q   <= '0;
      cyc_q   <= '0;
      load_q  <= 1'b0;
      go_q    <= 1'b0;
      kv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      trig_q  <= 1'b0;
      et_q    <= 1'b0;
      eo_q    <= 1'b0;
      er_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      wd_q    <= wd_d;
      len_q   <= len_d;
      blk_q   <= blk_d;
      cyc_q   <= cyc_d;
      load_q  <= load_d;
      go_q    <= go_d;
      kv_q    <= kv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      trig_q  <= trig_d;
      et_q    <= et_d;
      eo_q    <= eo_d;
      er_q    <= er_d;
    end
  end

  assign pipe_load_key   = load_q;
  assign pipe_encrypt_go = go_q;
  assign key_valid       = kv_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign trig            = trig_q;
  assign blocks_done     = blk_q;
  assign cycles          = cyc_q;
  assign err_timeout     = et_q;
  assign err_overrun     = eo_q;
  assign err_reject      = er_q;

endmodule

// File: tb/tb_aes_pipe_batch_ctrl.sv
// Bench for aes_pipe_batch_ctrl: transaction-level stimulus schedules the
// expected event cycles; a negedge monitor pops and compares them.
module tb_aes_pipe_batch_ctrl;

  logic        clk;
  logic        reset_n;
  logic        key_load_req;
  logic        go_req;
  logic [15:0] batch_len;
  logic        abort;
  logic        clear_errors;
  logic        pipe_busy;
  logic        pipe_block_done;
  logic        pipe_load_key;
  logic        pipe_encrypt_go;
  logic        key_valid;
  logic        busy;
  logic        done;
  logic        trig;
  logic [15:0] blocks_done;
  logic [31:0] cycles;
  logic        err_timeout;
  logic        err_overrun;
  logic        err_reject;

  int total;
  int bad;
  int cyc;

  int q_lk[$];
  int q_go[$];
  int q_kv[$];
  int q_rej[$];
  int q_ovr[$];
  int q_tmo[$];
  int q_tf[$];
  int q_bf[$];
  int q_done[$];
  int q_dbd[$];
  int q_dcy[$];

  aes_pipe_batch_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .key_load_req   (key_load_req),
    .go_req         (go_req),
    .batch_len      (batch_len),
    .abort          (abort),
    .clear_errors   (clear_errors),
    .pipe_busy      (pipe_busy),
    .pipe_block_done(pipe_block_done),
    .pipe_load_key  (pipe_load_key),
    .pipe_encrypt_go(pipe_encrypt_go),
    .key_valid      (key_valid),
    .busy           (busy),
    .done           (done),
    .trig           (trig),
    .blocks_done    (blocks_done),
    .cycles         (cycles),
    .err_timeout    (err_timeout),
    .err_overrun    (err_overrun),
    .err_reject     (err_reject)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string nm, input longint act,
                       input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int pop_ev(input int k);
    int r;
    r = -1;
    case (k)
      0: if (q_lk.size() > 0) r = q_lk.pop_front();
      1: if (q_go.size() > 0) r = q_go.pop_front();
      2: if (q_kv.size() > 0) r = q_kv.pop_front();
      3: if (q_rej.size() > 0) r = q_rej.pop_front();
      4: if (q_ovr.size() > 0) r = q_ovr.pop_front();
      5: if (q_tmo.size() > 0) r = q_tmo.pop_front();
      6: if (q_tf.size() > 0) r = q_tf.pop_front();
      7: if (q_bf.size() > 0) r = q_bf.pop_front();
      8: if (q_done.size() > 0) r = q_done.pop_front();
      default: r = -1;
    endcase
    return r;
  endfunction

  task automatic ev(input int k, input string nm);
    check(nm, cyc, pop_ev(k));
  endtask

  // Monitor: every observed event must match the next expected cycle.
  initial begin
    bit kv_p, rej_p, ovr_p, tmo_p, trig_p, busy_p;
    kv_p = 0; rej_p = 0; ovr_p = 0;
    tmo_p = 0; trig_p = 0; busy_p = 0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (pipe_load_key) ev(0, "load_key_cycle");
        if (pipe_encrypt_go) ev(1, "encrypt_go_cycle");
        if (key_valid && !kv_p) ev(2, "key_valid_rise");
        if (err_reject && !rej_p) ev(3, "err_reject_rise");
        if (err_overrun && !ovr_p) ev(4, "err_overrun_rise");
        if (err_timeout && !tmo_p) ev(5, "err_timeout_rise");
        if (trig_p && !trig) ev(6, "trig_fall");
        if (busy_p && !busy) ev(7, "busy_fall");
        if (done) begin
          ev(8, "done_cycle");
          if (q_dbd.size() > 0) begin
            check("done_blocks", blocks_done, q_dbd.pop_front());
            check("done_cycles", cycles, q_dcy.pop_front());
          end
          check("busy_low_with_done", busy, 0);
        end
      end
      kv_p   = key_valid;
      rej_p  = err_reject;
      ovr_p  = err_overrun;
      tmo_p  = err_timeout;
      trig_p = trig;
      busy_p = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    key_load_req    = 1'b0;
    go_req          = 1'b0;
    abort           = 1'b0;
    clear_errors    = 1'b0;
    pipe_busy       = 1'b0;
    pipe_block_done = 1'b0;
  endtask

  task automatic go_reject(input int len, input bit clr_same);
    int t;
    t = cyc;
    q_rej.push_back(t + 1);
    go_req = 1'b1;
    batch_len = 16'(len);
    clear_errors = clr_same;
    tick();
    idle();
    tick();
    check("reject_held", err_reject, 1);
    clear_errors = 1'b1;
    tick();
    idle();
    check("reject_cleared", err_reject, 0);
  endtask

  task automatic do_key(input bit inj, input bit both);
    int t;
    t = cyc;
    q_lk.push_back(t + 1);
    q_kv.push_back(t + 15);
    if (both) q_rej.push_back(t + 1);
    else if (inj) q_rej.push_back(t + 4);
    for (int cy = t; cy < t + 15; cy++) begin
      key_load_req = (cy == t);
      go_req = (both && cy == t) || (inj && cy == t + 3);
      batch_len = 16'd3;
      clear_errors = (both || inj) && (cy == t + 6);
      tick();
    end
    idle();
    check("key_valid_ready", key_valid, 1);
    check("errs_after_key", {err_timeout, err_overrun, err_reject}, 0);
  endtask

  task automatic run_batch(input int len, input bit inj,
                           input bit ovr, input int k);
    int t, c, g;
    int bd[$];
    t = cyc;
    c = t + 1;
    for (int i = 0; i < len; i++) begin
      g = (i == 0) ? int'($urandom_range(6, 3)) : int'($urandom_range(4, 1));
      c = c + g;
      bd.push_back(c);
    end
    q_go.push_back(t + 1);
    q_tf.push_back(c + 1);
    q_bf.push_back(c + k + 1);
    q_done.push_back(c + k + 1);
    q_dbd.push_back(len);
    q_dcy.push_back(c + k - t);
    if (inj) q_rej.push_back(t + 2);
    if (ovr) q_ovr.push_back(c + 2);
    for (int cy = t; cy <= c + k + 1; cy++) begin
      go_req = (cy == t) || (inj && cy == t + 1);
      batch_len = 16'(len);
      pipe_busy = (cy > t) && (cy < c + k);
      pipe_block_done = 1'b0;
      if (bd.size() > 0 && bd[0] == cy) begin
        pipe_block_done = 1'b1;
        bd.delete(0);
      end
      if (ovr && cy == c + 1) pipe_block_done = 1'b1;
      clear_errors = (inj && cy == t + 3) || (ovr && cy == c + 3);
      tick();
    end
    idle();
    check("held_blocks", blocks_done, len);
    check("held_cycles", cycles, c + k - t);
    check("busy_after", busy, 0);
    check("errs_after", {err_timeout, err_overrun, err_reject}, 0);
  endtask

  task automatic run_timeout();
    int t, c;
    t = cyc;
    c = t + 3;
    q_go.push_back(t + 1);
    q_tmo.push_back(c + 4097);
    q_tf.push_back(c + 4097);
    q_bf.push_back(c + 4097);
    for (int cy = t; cy <= c + 4097; cy++) begin
      go_req = (cy == t);
      batch_len = 16'd2;
      pipe_busy = (cy > t);
      pipe_block_done = (cy == c);
      tick();
    end
    idle();
    check("tmo_blocks", blocks_done, 1);
    check("tmo_cycles", cycles, c + 4096 - t);
    check("tmo_flag", err_timeout, 1);
    clear_errors = 1'b1;
    tick();
    idle();
    check("tmo_cleared", err_timeout, 0);
  endtask

  task automatic run_abort();
    int t;
    t = cyc;
    q_go.push_back(t + 1);
    q_tf.push_back(t + 6);
    q_bf.push_back(t + 6);
    for (int cy = t; cy <= t + 6; cy++) begin
      go_req = (cy == t);
      batch_len = 16'd5;
      pipe_busy = (cy > t);
      pipe_block_done = (cy == t + 3);
      abort = (cy == t + 5);
      tick();
    end
    idle();
    check("abort_blocks", blocks_done, 1);
    check("abort_busy", busy, 0);
  endtask

  task automatic key_abort();
    int t;
    t = cyc;
    q_lk.push_back(t + 1);
    key_load_req = 1'b1;
    tick();
    idle();
    repeat (3) tick();
    abort = 1'b1;
    tick();
    idle();
    tick();
    check("key_abort_kv", key_valid, 0);
    go_reject(4, 1'b0);
  endtask

  initial begin
    int len, k;
    bit inj, ovr;
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    batch_len = '0;
    idle();
    #2;
    check("rst_key_valid", key_valid, 0);
    check("rst_pulses", {pipe_load_key, pipe_encrypt_go, done, trig, busy}, 0);
    check("rst_counts", {blocks_done, cycles}, 0);
    check("rst_errs", {err_timeout, err_overrun, err_reject}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    go_reject(5, 1'b0);
    do_key(1'b0, 1'b0);
    go_reject(0, 1'b1);
    run_batch(3, 1'b0, 1'b0, 2);
    run_batch(2, 1'b0, 1'b1, 3);
    do_key(1'b0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      len = int'($urandom_range(6, 1));
      k = int'($urandom_range(4, 1));
      inj = 1'($urandom_range(1, 0));
      ovr = (k >= 2) && ($urandom_range(1, 0) == 1);
      run_batch(len, inj, ovr, k);
      if ($urandom_range(3, 0) == 0) do_key(1'($urandom_range(1, 0)), 1'b0);
    end

    run_timeout();
    run_batch(4, 1'b0, 1'b0, 1);
    run_abort();
    key_abort();
    do_key(1'b0, 1'b0);
    run_batch(2, 1'b1, 1'b0, 2);

    // Asynchronous reset in the middle of a key load.
    q_lk.push_back(cyc + 1);
    key_load_req = 1'b1;
    tick();
    idle();
    repeat (4) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_key_valid", key_valid, 0);
    check("areset_counts", {blocks_done, cycles}, 0);
    check("areset_flags", {busy, done, trig, pipe_load_key, pipe_encrypt_go}, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    go_reject(3, 1'b0);
    do_key(1'b0, 1'b0);
    run_batch(1, 1'b0, 1'b0, 1);

    repeat (5) tick();
    check("left_lk", q_lk.size(), 0);
    check("left_go", q_go.size(), 0);
    check("left_kv", q_kv.size(), 0);
    check("left_err", q_rej.size() + q_ovr.size() + q_tmo.size(), 0);
    check("left_falls", q_tf.size() + q_bf.size(), 0);
    check("left_done", q_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
